// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory req/ack FSM, branch resolve, MEM forwarding.
// Optional MEM_ALIGN_CHECK_EN: misaligned memops raise bus_err instead of issuing a request.
module mem_stage #(
  parameter int          MAX_WAIT = 15,
  parameter logic [31:0] RST_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_bubble,
  input  logic [4:0]  ex_reg_addr,
  input  logic [7:0]  ex_control,
  input  logic [31:0] ex_pc_target,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic        ex_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        fwd_is_load,
  output logic        bus_err,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [31:0] pc_tgt;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic        zero;
  } ex_mem_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  ex_mem_t    m;
  state_t     state;
  logic [7:0] wait_cnt;
  logic       memop;
  logic       is_load;
  logic       misalign;
  logic       ack;
  logic       err;
  logic       unused_ctrl;

  // alu_src and alu_op are consumed in EX only
  assign unused_ctrl = ^{ex_control[7], ex_control[1:0]};

  assign memop   = m.valid & (m.mem_read | m.mem_write);
  assign is_load = m.mem_read & ~m.mem_write;
  assign err     = (state == ERR);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (m.alu[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign dmem_req   = memop & ~misalign & ~err;
  assign ack        = dmem_req & dmem_ack;
  assign mem_stall  = memop & ~ack & ~err;
  assign dmem_we    = m.mem_write;
  assign dmem_addr  = m.alu;
  assign dmem_wdata = m.wdata;
  assign bus_err    = err;

  assign branch_taken  = m.valid & m.branch & m.zero & ~mem_stall;
  assign branch_target = m.pc_tgt;

  assign fwd_addr    = (m.valid & m.reg_write) ? m.rd : 5'd0;
  assign fwd_data    = m.alu;
  assign fwd_is_load = m.valid & m.mem_read;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m <= '{pc_tgt: RST_PC, default: '0};
    end else if (!mem_stall) begin
      m <= '{
        valid:      ~ex_bubble,
        rd:         ex_reg_addr,
        mem_to_reg: ex_control[6],
        reg_write:  ex_control[5],
        mem_read:   ex_control[4],
        mem_write:  ex_control[3],
        branch:     ex_control[2],
        pc_tgt:     ex_pc_target,
        alu:        ex_alu_result,
        wdata:      ex_write_data,
        zero:       ex_zero
      };
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop) begin
            if (misalign) begin
              state <= ERR;
            end else if (!ack) begin
              state    <= WAIT;
              wait_cnt <= 8'd1;
            end
          end
        end
        WAIT: begin
          if (ack) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(MAX_WAIT)) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a faulted access retires as a bubble; stores never write back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_addr   <= 5'd0;
      wb_alu_result <= 32'd0;
      wb_mem_data   <= 32'd0;
    end else if (mem_stall) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else begin
      wb_valid      <= m.valid & ~err;
      wb_reg_write  <= m.valid & m.reg_write & ~m.mem_write & ~err;
      wb_mem_to_reg <= m.valid & m.mem_to_reg & ~err;
      wb_reg_addr   <= m.rd;
      wb_alu_result <= m.alu;
      if (is_load & ack) begin
        wb_mem_data <= dmem_rdata;
      end
    end
  end

endmodule
